div_unit: RTL



---
 rtl/div_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- multi-cycle restoring integer divider for DIV / DIVU.
//
// Produces {remainder, quotient} for the HI/LO register pair (HI = remainder,
// LO = quotient). One quotient bit is resolved per clock. EX holds start_i high
// and stalls until ready_o is seen. A new divide needs start_i to drop for at
// least one cycle after the result has been taken.
//
// Configuration macro:
//   DIV_SIGNED_EN  defined   : signed_i selects signed (DIV) or unsigned (DIVU).
//                  undefined : signed_i is ignored, every divide is unsigned,
//                              and no absolute-value / sign-fix logic is built.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   signed_i   in   1 = signed divide, 0 = unsigned
//   opdata1_i  in   dividend (sampled only on the accepting edge)
//   opdata2_i  in   divisor  (sampled only on the accepting edge)
//   start_i    in   request, held high until ready_o
//   annul_i    in   cancel (flush / exception); ignored once the result is out
//   result_o   out  {remainder, quotient}, zero except while the result is out
//   ready_o    out  result valid
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module div_unit #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  input  logic            start_i,
  input  logic            annul_i,
  output logic [2*DW-1:0] result_o,
  output logic            ready_o
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ON     = 2'd1,
    S_BYZERO = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     rem_q, rem_d;     // partial remainder
  logic [DW-1:0]     dvd_q, dvd_d;     // dividend bits shifting out, quotient bits shifting in
  logic [DW-1:0]     dvs_q, dvs_d;     // divisor magnitude
  logic [2*DW-1:0]   result_q, result_d;
  logic              ready_q, ready_d;

  // Operand magnitudes presented to the datapath on the accepting edge
  logic [DW-1:0]     a_mag, b_mag;

`ifdef DIV_SIGNED_EN
  logic              negq_q, negq_d;   // quotient must be negated at the end
  logic              negr_q, negr_d;   // remainder must be negated at the end
  logic              a_neg, b_neg;

  assign a_neg = signed_i & opdata1_i[DW-1];
  assign b_neg = signed_i & opdata2_i[DW-1];
  // The most negative value maps onto itself, which is the correct unsigned
  // magnitude 2^(DW-1); this is what makes MIN / -1 wrap to MIN.
  assign a_mag = a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign b_mag = b_neg ? (~opdata2_i + 1'b1) : opdata2_i;
`else
  logic              unused_signed;
  assign unused_signed = signed_i;
  assign a_mag = opdata1_i;
  assign b_mag = opdata2_i;
`endif

  // One restoring step: shift the next dividend bit into the remainder, try
  // the subtraction one bit wider so a borrow shows up in the MSB.
  logic [DW:0]       rem_shift;
  logic [DW:0]       diff;
  logic              ge;
  logic [DW-1:0]     rem_step;
  logic [DW-1:0]     quo_step;
  logic [DW-1:0]     q_fin, r_fin;

  assign rem_shift = {rem_q, dvd_q[DW-1]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign ge        = ~diff[DW];
  assign rem_step  = ge ? diff[DW-1:0] : rem_shift[DW-1:0];
  assign quo_step  = {dvd_q[DW-2:0], ge};

`ifdef DIV_SIGNED_EN
  assign q_fin = negq_q ? (~quo_step + 1'b1) : quo_step;
  assign r_fin = negr_q ? (~rem_step + 1'b1) : rem_step;
`else
  assign q_fin = quo_step;
  assign r_fin = rem_step;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    ready_d  = 1'b0;
`ifdef DIV_SIGNED_EN
    negq_d   = negq_q;
    negr_d   = negr_q;
`endif

    case (state_q)
      S_IDLE: begin
        result_d = '0;
        if (start_i && !annul_i) begin
          dvd_d = a_mag;
          dvs_d = b_mag;
          rem_d = '0;
          cnt_d = '0;
`ifdef DIV_SIGNED_EN
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
`endif
          state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end

      S_ON: begin
        if (annul_i) begin
          result_d = '0;
          state_d  = S_IDLE;
        end else begin
          rem_d = rem_step;
          dvd_d = quo_step;
          cnt_d = cnt_q + CW'(1);
          // Last iteration: fold the sign fix into the same edge
          if (cnt_q == CW'(DW - 1)) begin
            result_d = {r_fin, q_fin};
            state_d  = S_END;
          end
        end
      end

      S_BYZERO: begin
        result_d = '0;
        state_d  = annul_i ? S_IDLE : S_END;
      end

      S_END: begin
        // ready_o follows one edge behind entry to END, so it rises the cycle
        // after the result register is loaded and falls on the very edge that
        // sees start_i low.
        if (start_i) begin
          ready_d = 1'b1;
        end else begin
          result_d = '0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        result_d = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      ready_q  <= ready_d;
`ifdef DIV_SIGNED_EN
      negq_q   <= negq_d;
      negr_q   <= negr_d;
`endif
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
